// File: rtl/bf16_acc_scheduler_if.sv
// Request/datapath/response bundle for the BF16 accelerator scheduler.
// master = requesters, response consumer and datapath model; slave = scheduler.
interface bf16_acc_scheduler_if #(
  parameter int unsigned ID_W = 4
);
  logic            req0_valid;
  logic            req0_ready;
  logic [3:0]      req0_op;
  logic [31:0]     req0_a;
  logic [31:0]     req0_b;
  logic [31:0]     req0_c;
  logic [ID_W-1:0] req0_id;

  logic            req1_valid;
  logic            req1_ready;
  logic [3:0]      req1_op;
  logic [31:0]     req1_a;
  logic [31:0]     req1_b;
  logic [31:0]     req1_c;
  logic [ID_W-1:0] req1_id;

  logic            acc_enable;
  logic [3:0]      acc_operation;
  logic [31:0]     acc_operand_a;
  logic [31:0]     acc_operand_b;
  logic [31:0]     acc_operand_c;
  logic [31:0]     acc_result;
  logic [31:0]     acc_fpcsr;
  logic            acc_valid;

  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_port;
  logic [ID_W-1:0] rsp_id;
  logic [31:0]     rsp_result;
  logic [1:0]      rsp_status;

  logic [4:0]      fpcsr_sticky;
  logic            fpcsr_clr;
  logic            busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_c, req0_id,
    output req1_valid, req1_op, req1_a, req1_b, req1_c, req1_id,
    input  req0_ready, req1_ready,
    input  acc_enable, acc_operation, acc_operand_a, acc_operand_b, acc_operand_c,
    output acc_result, acc_fpcsr, acc_valid,
    input  rsp_valid, rsp_port, rsp_id, rsp_result, rsp_status,
    output rsp_ready,
    input  fpcsr_sticky, busy,
    output fpcsr_clr
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_c, req0_id,
    input  req1_valid, req1_op, req1_a, req1_b, req1_c, req1_id,
    output req0_ready, req1_ready,
    output acc_enable, acc_operation, acc_operand_a, acc_operand_b, acc_operand_c,
    input  acc_result, acc_fpcsr, acc_valid,
    output rsp_valid, rsp_port, rsp_id, rsp_result, rsp_status,
    input  rsp_ready,
    output fpcsr_sticky, busy,
    input  fpcsr_clr
  );
endinterface

// File: rtl/bf16_acc_scheduler.sv
// Round-robin two-port scheduler/sequencer for the BF16 accelerator datapath.
// Optional EXEC watchdog enabled by defining BF16_SCHED_TIMEOUT_EN.
module bf16_acc_scheduler #(
  parameter int unsigned ID_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic                  clk,
  input logic                  reset,
  bf16_acc_scheduler_if.slave  bus
);
  localparam int unsigned CNT_W  = 8;
  localparam logic [3:0]  OP_MAX = 4'd10;
  localparam logic [1:0]  ST_OK  = 2'b00;
  localparam logic [1:0]  ST_ILL = 2'b01;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic            prio;
  logic            sel;
  logic            hs;
  logic [3:0]      op_s;
  logic [31:0]     a_s;
  logic [31:0]     b_s;
  logic [31:0]     c_s;
  logic [ID_W-1:0] id_s;
  logic            capture;
  logic [4:0]      sticky_nxt;

  logic [26:0]     unused_fpcsr_hi;
  assign unused_fpcsr_hi = bus.acc_fpcsr[31:5];

`ifdef BF16_SCHED_TIMEOUT_EN
  localparam logic [1:0] ST_TMO = 2'b10;
  logic [CNT_W-1:0] cnt;
`else
  logic [CNT_W-1:0] unused_timeout;
  assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
`endif

  // Grant selection: lone requester wins, ties go to the priority pointer.
  always_comb begin
    sel = prio;
    if (bus.req0_valid && !bus.req1_valid)      sel = 1'b0;
    else if (bus.req1_valid && !bus.req0_valid) sel = 1'b1;
    bus.req0_ready = (state == IDLE) && !reset && bus.req0_valid && !sel;
    bus.req1_ready = (state == IDLE) && !reset && bus.req1_valid && sel;
    hs         = bus.req0_ready || bus.req1_ready;
    op_s       = sel ? bus.req1_op : bus.req0_op;
    a_s        = sel ? bus.req1_a  : bus.req0_a;
    b_s        = sel ? bus.req1_b  : bus.req0_b;
    c_s        = sel ? bus.req1_c  : bus.req0_c;
    id_s       = sel ? bus.req1_id : bus.req0_id;
    capture    = (state == EXEC) && bus.acc_valid;
    // Clear takes effect before the freshly captured flags are merged in.
    sticky_nxt = (bus.fpcsr_clr ? 5'h00 : bus.fpcsr_sticky)
               | (capture ? bus.acc_fpcsr[4:0] : 5'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      prio              <= 1'b0;
      bus.acc_enable    <= 1'b0;
      bus.acc_operation <= '0;
      bus.acc_operand_a <= '0;
      bus.acc_operand_b <= '0;
      bus.acc_operand_c <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_port      <= 1'b0;
      bus.rsp_id        <= '0;
      bus.rsp_result    <= '0;
      bus.rsp_status    <= ST_OK;
      bus.fpcsr_sticky  <= '0;
      bus.busy          <= 1'b0;
`ifdef BF16_SCHED_TIMEOUT_EN
      cnt               <= '0;
`endif
    end else begin
      bus.fpcsr_sticky <= sticky_nxt;
      case (state)
        IDLE: begin
          if (hs) begin
            prio              <= ~sel;
            bus.acc_operation <= op_s;
            bus.acc_operand_a <= a_s;
            bus.acc_operand_b <= b_s;
            bus.acc_operand_c <= c_s;
            bus.rsp_port      <= sel;
            bus.rsp_id        <= id_s;
            bus.busy          <= 1'b1;
            if (op_s > OP_MAX) begin
              state          <= RESP;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_status <= ST_ILL;
              bus.rsp_result <= '0;
            end else begin
              state          <= EXEC;
              bus.acc_enable <= 1'b1;
`ifdef BF16_SCHED_TIMEOUT_EN
              cnt            <= '0;
`endif
            end
          end
        end
        EXEC: begin
`ifdef BF16_SCHED_TIMEOUT_EN
          cnt <= cnt + CNT_W'(1);
`endif
          if (bus.acc_valid) begin
            state          <= RESP;
            bus.acc_enable <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_status <= ST_OK;
            bus.rsp_result <= bus.acc_result;
          end
`ifdef BF16_SCHED_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state          <= RESP;
            bus.acc_enable <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_status <= ST_TMO;
            bus.rsp_result <= '0;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bf16_acc_scheduler.sv
// Directed + randomized bench for bf16_acc_scheduler against a transaction-level model.
module tb_bf16_acc_scheduler;
  localparam int TMO = 15;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [3:0]  id;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bf16_acc_scheduler_if #(.ID_W(4)) bus();
  bf16_acc_scheduler #(.ID_W(4), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // stimulus / datapath-model knobs
  req_t        rq[2];
  int          dp_dly;        // cycles of enable before valid; 0 = never
  logic [31:0] dp_res;
  logic [31:0] dp_fl;
  bit          clr_flag;
  int          hold;
  int          rst_at;
  int          tx_budget;
  int          ecnt;

  // reference model state
  int          last_g;
  logic [4:0]  m_sticky;

  // observations from txn
  int          o_port, o_lat, o_en, opbad, hold_bad, o_busylow;
  logic        o_rport, o_busy_after;
  logic [3:0]  o_rid;
  logic [31:0] o_rres;
  logic [1:0]  o_rst;

  // Datapath model: valid pulses after dp_dly cycles of continuous enable.
  always @(posedge clk) begin
    if (bus.acc_enable) begin
      ecnt          <= ecnt + 1;
      bus.acc_valid <= (dp_dly != 0) && (ecnt + 1 == dp_dly);
    end else begin
      ecnt          <= 0;
      bus.acc_valid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int win(input bit v0, input bit v1);
    if (v0 && v1) return (last_g == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_g = -1;
    m_sticky = 5'h00;
  endtask

  task automatic drive_reqs(input bit v0, input bit v1);
    bus.req0_valid = v0; bus.req0_op = rq[0].op; bus.req0_a = rq[0].a;
    bus.req0_b = rq[0].b; bus.req0_c = rq[0].c; bus.req0_id = rq[0].id;
    bus.req1_valid = v1; bus.req1_op = rq[1].op; bus.req1_a = rq[1].a;
    bus.req1_b = rq[1].b; bus.req1_c = rq[1].c; bus.req1_id = rq[1].id;
  endtask

  task automatic txn(input bit v0, input bit v1, input int w);
    bit got = 0;
    bus.acc_result = dp_res;
    bus.acc_fpcsr  = dp_fl;
    drive_reqs(v0, v1);
    o_port = 0; o_lat = 0; o_en = 0; opbad = 0; hold_bad = 0; o_busylow = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        o_port = bus.req1_ready ? 1 : 0;
        got = 1;
      end
      @(posedge clk); #1;
    end
    drive_reqs(1'b0, 1'b0);
    chk("grant_seen", 64'(got), 64'd1);
    for (int n = 1; n <= tx_budget; n++) begin
      if (bus.acc_enable) begin
        o_en++;
        if ({bus.acc_operation, bus.acc_operand_a, bus.acc_operand_b, bus.acc_operand_c}
            !== {rq[w].op, rq[w].a, rq[w].b, rq[w].c}) opbad++;
      end
      if (!bus.busy) o_busylow++;
      if (n == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      if (bus.rsp_valid) begin
        o_lat = n;
        o_rport = bus.rsp_port; o_rid = bus.rsp_id;
        o_rres = bus.rsp_result; o_rst = bus.rsp_status;
        break;
      end
      bus.fpcsr_clr = clr_flag && bus.acc_valid;
      @(posedge clk); #1;
    end
    bus.fpcsr_clr = 1'b0;
    if (o_lat == 0) return;
    for (int h = 0; h < hold; h++) begin
      drive_reqs(1'b1, 1'b1);
      #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_port !== o_rport || bus.rsp_id !== o_rid ||
          bus.rsp_result !== o_rres || bus.rsp_status !== o_rst ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) hold_bad++;
      @(posedge clk); #1;
    end
    drive_reqs(1'b0, 1'b0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    o_busy_after = bus.busy | bus.rsp_valid;
  endtask

  // Expected outcome of one transaction derived from the operation rules.
  task automatic check_txn(input int w);
    logic [1:0]  st;
    logic [31:0] r;
    int          lat, en;
    if (rq[w].op > 4'd10) begin
      st = 2'b01; r = 32'h0; lat = 1; en = 0;
    end else if (dp_dly == 0) begin
`ifdef BF16_SCHED_TIMEOUT_EN
      st = 2'b10; r = 32'h0; lat = TMO + 1; en = TMO;
`else
      st = 2'b00; r = 32'h0; lat = 0; en = tx_budget;
`endif
    end else begin
      st = 2'b00; r = dp_res; lat = dp_dly + 2; en = dp_dly + 1;
      m_sticky = (clr_flag ? 5'h00 : m_sticky) | dp_fl[4:0];
    end
    last_g = w;
    chk("grant_port", 64'(o_port), 64'(w));
    chk("rsp_latency", 64'(o_lat), 64'(lat));
    chk("enable_cycles", 64'(o_en), 64'(en));
    chk("operands_held", 64'(opbad), 64'd0);
    chk("sticky", 64'(bus.fpcsr_sticky), 64'(m_sticky));
    if (o_lat != 0) begin
      chk("rsp_port", 64'(o_rport), 64'(w));
      chk("rsp_id", 64'(o_rid), 64'(rq[w].id));
      chk("rsp_status", 64'(o_rst), 64'(st));
      chk("rsp_result", 64'(o_rres), 64'(r));
      chk("rsp_stable", 64'(hold_bad), 64'd0);
      chk("idle_after", 64'(o_busy_after), 64'd0);
    end else begin
      chk("busy_held", 64'(o_busylow), 64'd0);
    end
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a, input logic [3:0] id);
    rq[p].op = op; rq[p].a = a; rq[p].b = a ^ 32'h5A5A_0000; rq[p].c = ~a; rq[p].id = id;
  endtask

  task automatic set_dp(input int dly, input logic [31:0] res, input logic [31:0] fl, input bit clr, input int hd);
    dp_dly = dly; dp_res = res; dp_fl = fl; clr_flag = clr; hold = hd;
  endtask

  initial begin
    bit [1:0] v;
    int w;
    reset = 1'b1; bus.rsp_ready = 1'b0; bus.fpcsr_clr = 1'b0;
    bus.acc_result = '0; bus.acc_fpcsr = '0;
    rst_at = 0; tx_budget = 40;
    set_req(0, 4'h0, 32'h0, 4'h0); set_req(1, 4'h0, 32'h0, 4'h0);
    set_dp(1, 32'h0, 32'h0, 1'b0, 0);
    drive_reqs(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_enable", 64'(bus.acc_enable), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_sticky", 64'(bus.fpcsr_sticky), 64'd0);
    chk("rst_operation", 64'(bus.acc_operation), 64'd0);
    chk("rst_operand_a", 64'(bus.acc_operand_a), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
    drive_reqs(1'b0, 1'b0);
    reset = 1'b0;
    last_g = -1; m_sticky = 5'h00;

    // Single op on port 0 with a one-cycle datapath.
    set_req(0, 4'h1, 32'h3F80_0000, 4'd3);
    set_req(1, 4'h2, 32'h4000_0000, 4'd9);
    set_dp(1, 32'h0000_3F80, 32'h0, 1'b0, 0);
    txn(1'b1, 1'b0, 0); check_txn(0);

    // Port 1 alone, then both: port 0 next; then four contended ops.
    w = win(1'b0, 1'b1); txn(1'b0, 1'b1, w); check_txn(w);
    w = win(1'b1, 1'b1); txn(1'b1, 1'b1, w); check_txn(w);
    for (int i = 0; i < 4; i++) begin
      set_dp(1 + i, 32'h1000_0000 + 32'(i), 32'h0, 1'b0, 0);
      w = win(1'b1, 1'b1); txn(1'b1, 1'b1, w); check_txn(w);
    end

    // Illegal opcode.
    set_req(0, 4'hF, 32'h1234_5678, 4'd7);
    txn(1'b1, 1'b0, 0); check_txn(0);

    // Sticky accumulation, then clear coinciding with a capture.
    set_req(0, 4'h5, 32'h3F00_0000, 4'd1);
    set_dp(1, 32'hAAAA_0001, 32'hFFFF_FFE1, 1'b0, 0);
    txn(1'b1, 1'b0, 0); check_txn(0);
    set_dp(2, 32'hAAAA_0002, 32'h0000_0004, 1'b0, 0);
    txn(1'b1, 1'b0, 0); check_txn(0);
    set_dp(1, 32'hAAAA_0003, 32'h0000_0010, 1'b1, 0);
    txn(1'b1, 1'b0, 0); check_txn(0);

    // Response backpressure for five cycles.
    set_req(1, 4'hA, 32'hC000_0000, 4'd12);
    set_dp(3, 32'hBEEF_0000, 32'h0, 1'b0, 5);
    txn(1'b0, 1'b1, 1); check_txn(1);

    // Reset during the second EXEC cycle drops the op.
    set_req(0, 4'h3, 32'h4040_0000, 4'd5);
    set_dp(0, 32'h0, 32'h0, 1'b0, 0);
    rst_at = 2;
    txn(1'b1, 1'b0, 0);
    rst_at = 0;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_enable", 64'(bus.acc_enable), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_sticky", 64'(bus.fpcsr_sticky), 64'd0);
    chk("mid_rst_operation", 64'(bus.acc_operation), 64'd0);
    last_g = -1; m_sticky = 5'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    set_dp(1, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
    w = win(1'b1, 1'b1); txn(1'b1, 1'b1, w); check_txn(w);

    // Datapath that never answers.
    set_dp(0, 32'h0, 32'h0, 1'b0, 0);
    tx_budget = 100;
    txn(1'b1, 1'b0, 0); check_txn(0);
    tx_budget = 40;
`ifndef BF16_SCHED_TIMEOUT_EN
    do_reset();
`endif

    // Randomized mix of ports, opcodes, latencies, flags and backpressure.
    for (int i = 0; i < 12; i++) begin
      v = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        rq[p].op = 4'($urandom_range(0, 15));
        rq[p].a = $urandom(); rq[p].b = $urandom(); rq[p].c = $urandom();
        rq[p].id = 4'($urandom_range(0, 15));
      end
      set_dp($urandom_range(1, 5), $urandom(), $urandom(), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      w = win(v[0], v[1]); txn(v[0], v[1], w); check_txn(w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
